// File: rtl/fetch_pkg.sv
// fetch_pkg: opcodes, FSM states and instruction field positions shared by the fetch/branch unit.
package fetch_pkg;
  typedef enum logic [3:0] {OP_BR = 4'hC, OP_BRZ = 4'hD, OP_JMP = 4'hE, OP_HALT = 4'hF} opcode_t;
  typedef enum logic [1:0] {IDLE, FETCH, JMP_TGT, HALTED} state_t;
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int OFF_MSB = 8;
endpackage

// File: rtl/fetch_decode.sv
// fetch_decode: classifies a fetched word as BR/BRZ/JMP/HALT and extracts its signed offset field.
module fetch_decode
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH   = 16,
  parameter int OFFSET_WIDTH = 9
) (
  input  logic [ADDR_WIDTH-1:0]   mem_data,
  output logic                    is_br,
  output logic                    is_brz,
  output logic                    is_jmp,
  output logic                    is_halt,
  output logic [OFFSET_WIDTH-1:0] offset
);
  logic [3:0] opc;
  logic unused_bits;
  assign opc         = mem_data[OPC_MSB:OPC_LSB];
  assign is_br       = opc == OP_BR;
  assign is_brz      = opc == OP_BRZ;
  assign is_jmp      = opc == OP_JMP;
  assign is_halt     = opc == OP_HALT;
  assign offset      = mem_data[OFF_MSB:0];
  assign unused_bits = ^mem_data[OPC_LSB-1:OFF_MSB+1];
endmodule

// File: rtl/fetch_branch_unit.sv
// fetch_branch_unit: fetches at the PC, steers the PC for BR/BRZ/JMP/HALT and issues ordinary instructions.
// Define FETCH_BRANCH_COUNT_EN to build the saturating taken-branch counter on BranchCount.
module fetch_branch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH   = 16,
  parameter int OFFSET_WIDTH = 9
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [ADDR_WIDTH-1:0]   CounterValue,
  output logic [ADDR_WIDTH-1:0]   LoadValue,
  output logic                    LoadEnable,
  output logic [OFFSET_WIDTH-1:0] Offset,
  output logic                    OffsetEnable,
  output logic                    MemReq,
  output logic [ADDR_WIDTH-1:0]   MemAddr,
  input  logic                    MemAck,
  input  logic [ADDR_WIDTH-1:0]   MemData,
  input  logic                    Zero,
  output logic [ADDR_WIDTH-1:0]   Instr,
  output logic                    InstrValid,
  input  logic                    InstrReady,
  output logic                    Halted,
  output logic [15:0]             BranchCount
);
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] instr_q, instr_d;
  logic instr_valid_q, instr_valid_d, halted_q, halted_d;
  logic is_br, is_brz, is_jmp, is_halt;
  logic [OFFSET_WIDTH-1:0] dec_offset;
  logic stall, fetch_ack, take_br, ordinary, advance;
  fetch_decode #(.ADDR_WIDTH(ADDR_WIDTH), .OFFSET_WIDTH(OFFSET_WIDTH)) u_decode (
    .mem_data (MemData),
    .is_br    (is_br),
    .is_brz   (is_brz),
    .is_jmp   (is_jmp),
    .is_halt  (is_halt),
    .offset   (dec_offset)
  );
  // Everything that is not an increment or a load is a hold (offset 0) or a taken branch.
  always_comb begin
    stall         = instr_valid_q & ~InstrReady;
    fetch_ack     = state_q == FETCH && !stall && MemAck;
    take_br       = fetch_ack && (is_br || (is_brz && Zero));
    ordinary      = fetch_ack && !(is_br || is_brz || is_jmp || is_halt);
    advance       = fetch_ack && !take_br && !is_halt;
    MemReq        = (state_q == FETCH && !stall) || state_q == JMP_TGT;
    MemAddr       = CounterValue;
    LoadEnable    = state_q == JMP_TGT && MemAck;
    LoadValue     = LoadEnable ? MemData : '0;
    Offset        = take_br ? dec_offset : '0;
    OffsetEnable  = !LoadEnable && !advance;
    state_d       = state_q == IDLE ? FETCH :
                    (fetch_ack && is_jmp) ? JMP_TGT :
                    (fetch_ack && is_halt) ? HALTED :
                    LoadEnable ? FETCH : state_q;
    instr_d       = ordinary ? MemData : instr_q;
    instr_valid_d = ordinary | stall;
    halted_d      = halted_q | (fetch_ack && is_halt);
  end
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q       <= IDLE;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
    end
  end
  assign Instr      = instr_q;
  assign InstrValid = instr_valid_q;
  assign Halted     = halted_q;
`ifdef FETCH_BRANCH_COUNT_EN
  logic [15:0] bcnt_q, bcnt_d;
  always_comb begin
    bcnt_d = ((take_br || LoadEnable) && bcnt_q != 16'hFFFF) ? bcnt_q + 16'd1 : bcnt_q;
  end
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) bcnt_q <= '0;
    else bcnt_q <= bcnt_d;
  end
  assign BranchCount = bcnt_q;
`else
  assign BranchCount = '0;
`endif
endmodule

// File: tb/tb_fetch_branch_unit.sv
// tb_fetch_branch_unit: PC model plus wait-state memory around the DUT; issued instructions are scoreboarded.
module tb_fetch_branch_unit;
  logic clk = 0, rst = 1;
  logic [15:0] pc, LoadValue, Offset16, MemAddr, MemData, Instr, BranchCount;
  logic [8:0] Offset;
  logic LoadEnable, OffsetEnable, MemReq, MemAck, InstrValid, Halted;
  logic Zero = 0, InstrReady = 1;
  logic [15:0] mem [0:65535];
  logic [15:0] wait_addr = 16'h0000;
  int wait_n = 0, wcnt;
  int vectors = 0, fails = 0;
  logic [15:0] exp_q [$];

  fetch_branch_unit #(.ADDR_WIDTH(16), .OFFSET_WIDTH(9)) dut (
    .Clock(clk), .Reset(rst), .CounterValue(pc), .LoadValue(LoadValue), .LoadEnable(LoadEnable),
    .Offset(Offset), .OffsetEnable(OffsetEnable), .MemReq(MemReq), .MemAddr(MemAddr),
    .MemAck(MemAck), .MemData(MemData), .Zero(Zero), .Instr(Instr), .InstrValid(InstrValid),
    .InstrReady(InstrReady), .Halted(Halted), .BranchCount(BranchCount)
  );

  always #5 clk = ~clk;

  assign Offset16 = {{7{Offset[8]}}, Offset};
  always @(posedge clk or posedge rst)
    if (rst) pc <= 16'h0;
    else if (LoadEnable) pc <= LoadValue;
    else if (OffsetEnable) pc <= pc + Offset16;
    else pc <= pc + 16'd1;

  assign MemAck  = MemReq && (wcnt >= ((MemAddr == wait_addr) ? wait_n : 0));
  assign MemData = mem[MemAddr];
  always @(posedge clk or posedge rst)
    if (rst) wcnt <= 0;
    else if (MemReq && !MemAck) wcnt <= wcnt + 1;
    else wcnt <= 0;

  // Scoreboard monitor: every accepted issue must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst && InstrValid && InstrReady) begin
      vectors++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL issue: got unexpected Instr %h, expected none", Instr);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (Instr !== e) begin
          fails++;
          $display("FAIL issue: got Instr %h, expected %h", Instr, e);
        end
      end
    end
    if (!rst && LoadEnable && OffsetEnable) begin
      vectors++;
      fails++;
      $display("FAIL exclusive: got LoadEnable=1 OffsetEnable=1, expected at most one");
    end
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  function automatic logic [31:0] bc_exp(input int n);
`ifdef FETCH_BRANCH_COUNT_EN
    return n;
`else
    return 0;
`endif
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1;
    InstrReady = 1;
    Zero = 0;
    wait_n = 0;
    exp_q.delete();
    for (int i = 0; i < 65536; i++) mem[i] = 16'hF000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", InstrValid, 0);
    chk("rst_halted", Halted, 0);
    chk("rst_memreq", MemReq, 0);
    chk("rst_instr", Instr, 0);
    chk("rst_bcnt", BranchCount, 0);
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic wait_req(input logic [15:0] a, input int budget);
    int n = 0;
    @(negedge clk);
    while (!(MemReq && MemAddr == a) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("req_%h", a), {31'b0, MemReq && MemAddr == a}, 1);
  endtask

  task automatic finish_test(input string n, input logic [15:0] exp_pc, input int bc);
    int k = 0;
    while (!Halted && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk({n, "_halted"}, Halted, 1);
    chk({n, "_pc"}, pc, exp_pc);
    chk({n, "_bcnt"}, BranchCount, bc_exp(bc));
    chk({n, "_drain"}, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // Ordinary word at 0, zero wait states, then HALT at 1.
    do_reset();
    mem[0] = 16'h1234;
    exp_q.push_back(16'h1234);
    finish_test("plain", 16'h0001, 0);

    // JMP to 6, BR -4 at 6 with two wait cycles lands on 2.
    do_reset();
    mem[0] = 16'hE000; mem[1] = 16'h0006; mem[6] = 16'hC1FC;
    wait_addr = 16'h0006; wait_n = 2;
    wait_req(16'h0006, 50);
    @(negedge clk);
    chk("br_hold1_pc", pc, 16'h0006);
    chk("br_hold1_ack", MemAck, 0);
    @(negedge clk);
    chk("br_hold2_pc", pc, 16'h0006);
    chk("br_ack_offen", OffsetEnable, 1);
    chk("br_ack_off", Offset, 9'h1FC);
    @(negedge clk);
    chk("br_target_pc", pc, 16'h0002);
    chk("br_no_issue", InstrValid, 0);
    finish_test("br", 16'h0002, 2);

    // BRZ +5 at 3, taken and not taken.
    for (int z = 0; z < 2; z++) begin
      do_reset();
      Zero = z[0];
      for (int i = 0; i < 3; i++) begin
        mem[i] = 16'h2000 + 16'(i);
        exp_q.push_back(16'h2000 + 16'(i));
      end
      mem[3] = 16'hD005;
      finish_test(z ? "brz_taken" : "brz_fall", z ? 16'h0008 : 16'h0004, z);
    end

    // Ten back-to-back issues, then JMP at 10 through word 11.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      mem[i] = 16'h3000 + 16'(i);
      exp_q.push_back(16'h3000 + 16'(i));
    end
    mem[10] = 16'hE000; mem[11] = 16'hF0F0;
    wait_req(16'h000B, 100);
    chk("jmp_load_en", LoadEnable, 1);
    chk("jmp_load_val", LoadValue, 16'hF0F0);
    @(negedge clk);
    chk("jmp_pc", pc, 16'hF0F0);
    chk("jmp_load_pulse", LoadEnable, 0);
    finish_test("jmp", 16'hF0F0, 1);

    // Output back-pressure stalls fetching until the consumer takes the word.
    do_reset();
    InstrReady = 0;
    mem[0] = 16'h4444; mem[1] = 16'h5555;
    exp_q.push_back(16'h4444);
    exp_q.push_back(16'h5555);
    begin
      int n = 0;
      @(negedge clk);
      while (!InstrValid && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    repeat (2) begin
      chk("stall_memreq", MemReq, 0);
      chk("stall_pc", pc, 16'h0001);
      chk("stall_instr", Instr, 16'h4444);
      @(negedge clk);
    end
    @(posedge clk); #1;
    InstrReady = 1;
    @(negedge clk);
    chk("resume_memreq", MemReq, 1);
    chk("resume_addr", MemAddr, 16'h0001);
    finish_test("stall", 16'h0002, 0);

    // HALT at 20 holds the PC indefinitely.
    do_reset();
    mem[0] = 16'hC014;
    finish_test("halt", 16'h0014, 1);
    for (int i = 0; i < 5; i++) begin
      repeat (10) @(negedge clk);
      chk("halt_hold_pc", pc, 16'h0014);
      chk("halt_hold_req", MemReq, 0);
    end

    // Wrap both ways: 2 + (-4) = FFFE, then FFFF + 5 = 0004.
    do_reset();
    mem[0] = 16'hE000; mem[1] = 16'h0002; mem[2] = 16'hC1FC;
    mem[16'hFFFE] = 16'h6666; mem[16'hFFFF] = 16'hC005;
    exp_q.push_back(16'h6666);
    finish_test("wrap", 16'h0004, 3);

    // Async reset while JMP_TGT waits for its target word.
    do_reset();
    mem[0] = 16'hE000; mem[1] = 16'h1234;
    wait_addr = 16'h0001; wait_n = 100;
    wait_req(16'h0001, 50);
    repeat (3) @(negedge clk);
    @(posedge clk); #3;
    rst = 1;
    #1;
    chk("mid_rst_memreq", MemReq, 0);
    chk("mid_rst_valid", InstrValid, 0);
    chk("mid_rst_halted", Halted, 0);
    chk("mid_rst_bcnt", BranchCount, 0);
    chk("mid_rst_pc", pc, 0);
    wait_n = 0;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("post_rst_idle", MemReq, 0);
    @(negedge clk);
    chk("post_rst_req", MemReq, 1);
    chk("post_rst_addr", MemAddr, 16'h0000);
    finish_test("mid_rst", 16'h1234, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
